// File: rtl/fifo_package.sv
// Shared definitions for the parity-protected FIFO: reader buffer depth, reader FSM
// states and the parity predicate used by both writer self-check and reader.
package fifo_package;

    localparam int BUF_DEPTH = 3;

    typedef enum logic {RUN, HALT} rd_state_t;

    // word_xor is the XOR-reduction of the full stored word; odd_type selects ODD parity.
    function automatic logic parity_ok(input logic word_xor, input logic odd_type);
        return word_xor == odd_type;
    endfunction

endpackage

// File: rtl/fifo_parity_chk.sv
// Combinational parity check and payload extraction for one stored FIFO word.
module fifo_parity_chk
    import fifo_package::*;
#(
    parameter int    WIDTH       = 32,
    parameter int    DATA_WIDTH  = WIDTH + 1,
    parameter string PARITY_BIT  = "MSB",
    parameter string PARITY_TYPE = "EVEN"
) (
    input  logic [DATA_WIDTH-1:0] word_i,
    output logic [WIDTH-1:0]      data_o,
    output logic                  perr_o
);

    localparam logic ODD_TYPE = (PARITY_TYPE == "ODD");
    localparam int   P_SHIFT  = (PARITY_BIT == "LSB") ? 1 : 0;

    assign perr_o = !parity_ok(^word_i, ODD_TYPE);
    // LSB parity sits at bit 0, so the payload is the word shifted down by one.
    assign data_o = WIDTH'(word_i >> P_SHIFT);

endmodule

// File: rtl/fifo_parity_reader.sv
// Read-side consumer of the parity FIFO: pops words, checks/strips parity, streams them out.
// Optional error counter (err_cnt port/register) is built when PARITY_ERR_CNT_EN is defined.
module fifo_parity_reader
    import fifo_package::*;
#(
    parameter int    WIDTH       = 32,
    parameter int    DATA_WIDTH  = WIDTH + 1,
    parameter string PARITY_BIT  = "MSB",
    parameter string PARITY_TYPE = "EVEN",
    parameter int    HALT_ON_ERR = 1
`ifdef PARITY_ERR_CNT_EN
    , parameter int  CNT_WIDTH   = 8
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WIDTH-1:0]      m_data,
    output logic                  m_perr,
    output logic                  err_sticky,
    output logic                  halted,
    input  logic                  err_clr
`ifdef PARITY_ERR_CNT_EN
    , output logic [CNT_WIDTH-1:0] err_cnt
`endif
);

    rd_state_t        state_q, state_d;
    logic [WIDTH:0]   buf_q [BUF_DEPTH];
    logic [WIDTH:0]   buf_d [BUF_DEPTH];
    logic [1:0]       cnt_q, cnt_d;
    logic             rd_pend_q;
    logic             sticky_q, sticky_d;
    logic [WIDTH-1:0] cap_data;
    logic             cap_perr;
    logic             cap_err;
    logic             pop;

    fifo_parity_chk #(
        .WIDTH       (WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .PARITY_BIT  (PARITY_BIT),
        .PARITY_TYPE (PARITY_TYPE)
    ) u_chk (
        .word_i (fifo_rdata),
        .data_o (cap_data),
        .perr_o (cap_perr)
    );

    // Stream handshake: a word transfers on a cycle where m_valid && m_ready; m_valid,
    // m_data and m_perr stay stable until then, and m_valid never depends on m_ready.
    assign pop     = (cnt_q != 2'd0) && m_ready;
    assign cap_err = rd_pend_q && cap_perr;

    // Reads are reserved against buffer space including the one in flight, so the
    // buffer cannot overflow and m_ready never reaches fifo_rd_en.
    assign fifo_rd_en = rst_n && (state_q == RUN) && !fifo_empty
                        && ((3'(cnt_q) + 3'(rd_pend_q)) < 3'(BUF_DEPTH));

    assign m_valid    = (cnt_q != 2'd0);
    assign m_data     = buf_q[0][WIDTH-1:0];
    assign m_perr     = buf_q[0][WIDTH];
    assign halted     = (state_q == HALT);
    assign err_sticky = sticky_q;

    always_comb begin
        for (int i = 0; i < BUF_DEPTH; i++) buf_d[i] = buf_q[i];
        cnt_d = cnt_q;
        if (pop) begin
            for (int i = 0; i < BUF_DEPTH - 1; i++) buf_d[i] = buf_q[i+1];
            cnt_d = cnt_q - 2'd1;
        end
        if (rd_pend_q) begin
            buf_d[cnt_d] = {cap_perr, cap_data};
            cnt_d        = cnt_d + 2'd1;
        end
    end

    // A captured error overrides a simultaneous clear.
    always_comb begin
        state_d  = state_q;
        sticky_d = sticky_q;
        if (err_clr) begin
            sticky_d = 1'b0;
            if (state_q == HALT) state_d = RUN;
        end
        if (cap_err) begin
            sticky_d = 1'b1;
            if (HALT_ON_ERR != 0) state_d = HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RUN;
            cnt_q     <= 2'd0;
            rd_pend_q <= 1'b0;
            sticky_q  <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= fifo_rd_en;
            sticky_q  <= sticky_d;
            for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= buf_d[i];
        end
    end

`ifdef PARITY_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_clr ? '0 : err_cnt_q;
        if (cap_err && !(&err_cnt_d)) err_cnt_d = err_cnt_d + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_parity_reader.sv
// Directed bench for fifo_parity_reader: three instances (EVEN/MSB halting, ODD/LSB,
// non-halting) each fed by a simple 1-cycle-latency FIFO model.
module tb_fifo_parity_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n   = 1'b0;
    logic m_ready = 1'b0;
    logic err_clr = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- instance A: EVEN / MSB / HALT_ON_ERR=1
    logic        rd_en_a, empty_a, m_valid_a, m_perr_a, sticky_a, halted_a;
    logic [32:0] rdata_a;
    logic [31:0] m_data_a;
    logic [32:0] mem_a [0:511];
    int          wp_a = 0, rp_a = 0;
    assign empty_a = (wp_a == rp_a);
    always @(posedge clk) if (rd_en_a) begin rdata_a <= mem_a[rp_a]; rp_a <= rp_a + 1; end

    // ---------------- instance B: ODD / LSB / HALT_ON_ERR=1
    logic        rd_en_b, empty_b, m_valid_b, m_perr_b, sticky_b, halted_b;
    logic [32:0] rdata_b;
    logic [31:0] m_data_b;
    logic [32:0] mem_b [0:511];
    int          wp_b = 0, rp_b = 0;
    assign empty_b = (wp_b == rp_b);
    always @(posedge clk) if (rd_en_b) begin rdata_b <= mem_b[rp_b]; rp_b <= rp_b + 1; end

    // ---------------- instance C: EVEN / MSB / HALT_ON_ERR=0
    logic        rd_en_c, empty_c, m_valid_c, m_perr_c, sticky_c, halted_c;
    logic [32:0] rdata_c;
    logic [31:0] m_data_c;
    logic [32:0] mem_c [0:511];
    int          wp_c = 0, rp_c = 0;
    assign empty_c = (wp_c == rp_c);
    always @(posedge clk) if (rd_en_c) begin rdata_c <= mem_c[rp_c]; rp_c <= rp_c + 1; end

`ifdef PARITY_ERR_CNT_EN
    logic [7:0] err_cnt_a, err_cnt_b, err_cnt_c;
`endif

    fifo_parity_reader dut_a (
        .clk(clk), .rst_n(rst_n), .fifo_empty(empty_a), .fifo_rd_en(rd_en_a),
        .fifo_rdata(rdata_a), .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a),
        .m_perr(m_perr_a), .err_sticky(sticky_a), .halted(halted_a), .err_clr(err_clr)
`ifdef PARITY_ERR_CNT_EN
        , .err_cnt(err_cnt_a)
`endif
    );

    fifo_parity_reader #(.PARITY_BIT("LSB"), .PARITY_TYPE("ODD")) dut_b (
        .clk(clk), .rst_n(rst_n), .fifo_empty(empty_b), .fifo_rd_en(rd_en_b),
        .fifo_rdata(rdata_b), .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b),
        .m_perr(m_perr_b), .err_sticky(sticky_b), .halted(halted_b), .err_clr(err_clr)
`ifdef PARITY_ERR_CNT_EN
        , .err_cnt(err_cnt_b)
`endif
    );

    fifo_parity_reader #(.HALT_ON_ERR(0)
`ifdef PARITY_ERR_CNT_EN
        , .CNT_WIDTH(8)
`endif
    ) dut_c (
        .clk(clk), .rst_n(rst_n), .fifo_empty(empty_c), .fifo_rd_en(rd_en_c),
        .fifo_rdata(rdata_c), .m_valid(m_valid_c), .m_ready(m_ready), .m_data(m_data_c),
        .m_perr(m_perr_c), .err_sticky(sticky_c), .halted(halted_c), .err_clr(err_clr)
`ifdef PARITY_ERR_CNT_EN
        , .err_cnt(err_cnt_c)
`endif
    );

    // ---------------- driver tasks
    task automatic push_a(input logic [32:0] w); mem_a[wp_a] = w; wp_a++; endtask
    task automatic push_b(input logic [32:0] w); mem_b[wp_b] = w; wp_b++; endtask
    task automatic push_c(input logic [32:0] w); mem_c[wp_c] = w; wp_c++; endtask

    function automatic logic [32:0] mk_even(input logic [31:0] d);
        return {^d, d};
    endfunction

    // ---------------- tests
    task automatic test_reset();
        rst_n = 1'b0; m_ready = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if ({m_valid_a, m_perr_a, m_data_a} !== 34'd0) begin miscompares++;
            $display("FAIL reset_out_a: got %h want 0", {m_valid_a, m_perr_a, m_data_a}); end
        vectors++; if ({halted_a, sticky_a, rd_en_a} !== 3'b000) begin miscompares++;
            $display("FAIL reset_flags_a: got %b want 000", {halted_a, sticky_a, rd_en_a}); end
        vectors++; if ({m_valid_b, halted_b, m_valid_c, halted_c, sticky_c} !== 5'b0) begin miscompares++;
            $display("FAIL reset_bc: got %b want 00000", {m_valid_b, halted_b, m_valid_c, halted_c, sticky_c}); end
`ifdef PARITY_ERR_CNT_EN
        vectors++; if (err_cnt_c !== 8'd0) begin miscompares++;
            $display("FAIL reset_cnt: got %0d want 0", err_cnt_c); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stream();
        m_ready = 1'b1;
        push_a(33'h1_0000_0001); push_a(33'h1_0000_0002); push_a(33'h0_0000_0003);
        #1;
        vectors++; if ({rd_en_a, m_valid_a} !== 2'b10) begin miscompares++;
            $display("FAIL stream_issue: got rd_en,valid=%b want 10", {rd_en_a, m_valid_a}); end
        @(negedge clk);
        vectors++; if (m_valid_a !== 1'b0) begin miscompares++;
            $display("FAIL stream_lat1: got valid=%b want 0", m_valid_a); end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            vectors++; if ({m_valid_a, m_perr_a, m_data_a} !== {1'b1, 1'b0, 32'(i)}) begin miscompares++;
                $display("FAIL stream_word%0d: got %h want %h", i, {m_valid_a, m_perr_a, m_data_a}, {1'b1, 1'b0, 32'(i)}); end
        end
        @(negedge clk);
        vectors++; if (m_valid_a !== 1'b0) begin miscompares++;
            $display("FAIL stream_end: got valid=%b want 0", m_valid_a); end
    endtask

    task automatic test_halt_on_err();
        logic [31:0] got[$];
        int rd_seen = 0;
        m_ready = 1'b1;
        push_a(33'h0_0000_0001); push_a(33'h1_0000_0002); push_a(33'h0_0000_0003);
        push_a(33'h1_0000_0004); push_a(33'h0_0000_0005);
        @(negedge clk);
        @(negedge clk);
        vectors++; if ({m_valid_a, m_perr_a, m_data_a} !== {1'b1, 1'b1, 32'd1}) begin miscompares++;
            $display("FAIL halt_bad_word: got %h want %h", {m_valid_a, m_perr_a, m_data_a}, {1'b1, 1'b1, 32'd1}); end
        vectors++; if ({halted_a, sticky_a} !== 2'b11) begin miscompares++;
            $display("FAIL halt_flags: got halted,sticky=%b want 11", {halted_a, sticky_a}); end
        @(negedge clk);
        vectors++; if ({m_valid_a, m_perr_a, m_data_a} !== {1'b1, 1'b0, 32'd2}) begin miscompares++;
            $display("FAIL halt_inflight: got %h want %h", {m_valid_a, m_perr_a, m_data_a}, {1'b1, 1'b0, 32'd2}); end
        repeat (5) begin
            @(negedge clk);
            if (rd_en_a) rd_seen++;
        end
        vectors++; if (rd_seen !== 0) begin miscompares++;
            $display("FAIL halt_no_reads: got %0d rd_en cycles want 0", rd_seen); end
        vectors++; if ({halted_a, m_valid_a} !== 2'b10) begin miscompares++;
            $display("FAIL halt_hold: got halted,valid=%b want 10", {halted_a, m_valid_a}); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        vectors++; if ({halted_a, sticky_a} !== 2'b00) begin miscompares++;
            $display("FAIL halt_clear: got halted,sticky=%b want 00", {halted_a, sticky_a}); end
        for (int i = 0; i < 12; i++) begin
            if (m_valid_a) got.push_back(m_data_a);
            @(negedge clk);
        end
        vectors++; if (got.size() !== 3) begin miscompares++;
            $display("FAIL halt_resume_cnt: got %0d words want 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            vectors++; if (i >= got.size() || got[i] !== 32'(i + 3)) begin miscompares++;
                $display("FAIL halt_resume_word%0d: got %h want %h", i, (i < got.size()) ? got[i] : 32'hx, 32'(i + 3)); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] got[$];
        int pulses = 0;
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push_a(mk_even(32'(i * 16)));
        repeat (10) begin
            #1;
            if (rd_en_a) pulses++;
            @(negedge clk);
        end
        vectors++; if (pulses !== 3) begin miscompares++;
            $display("FAIL bp_rd_pulses: got %0d want 3", pulses); end
        vectors++; if ({m_valid_a, m_data_a} !== {1'b1, 32'h10}) begin miscompares++;
            $display("FAIL bp_head: got %h want %h", {m_valid_a, m_data_a}, {1'b1, 32'h10}); end
        m_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (m_valid_a) got.push_back(m_data_a);
            @(negedge clk);
        end
        vectors++; if (got.size() !== 5) begin miscompares++;
            $display("FAIL bp_count: got %0d words want 5", got.size()); end
        for (int i = 0; i < 5; i++) begin
            vectors++; if (i >= got.size() || got[i] !== 32'((i + 1) * 16)) begin miscompares++;
                $display("FAIL bp_word%0d: got %h want %h", i, (i < got.size()) ? got[i] : 32'hx, 32'((i + 1) * 16)); end
        end
    endtask

    task automatic test_odd_lsb();
        m_ready = 1'b1;
        push_b({32'hFFFF_FFFF, 1'b1});
        push_b({32'hFFFF_FFFF, 1'b0});
        @(negedge clk);
        @(negedge clk);
        vectors++; if ({m_valid_b, m_perr_b, m_data_b} !== {1'b1, 1'b0, 32'hFFFF_FFFF}) begin miscompares++;
            $display("FAIL odd_lsb_good: got %h want %h", {m_valid_b, m_perr_b, m_data_b}, {1'b1, 1'b0, 32'hFFFF_FFFF}); end
        @(negedge clk);
        vectors++; if ({m_valid_b, m_perr_b, m_data_b} !== {1'b1, 1'b1, 32'hFFFF_FFFF}) begin miscompares++;
            $display("FAIL odd_lsb_bad: got %h want %h", {m_valid_b, m_perr_b, m_data_b}, {1'b1, 1'b1, 32'hFFFF_FFFF}); end
        vectors++; if ({sticky_b, halted_b} !== 2'b11) begin miscompares++;
            $display("FAIL odd_lsb_flags: got sticky,halted=%b want 11", {sticky_b, halted_b}); end
    endtask

    task automatic test_reset_inflight();
        logic [31:0] got[$];
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push_a(mk_even(32'h60 + 32'(i)));
        repeat (3) @(negedge clk);
        vectors++; if ({m_valid_a, m_data_a} !== {1'b1, 32'h61}) begin miscompares++;
            $display("FAIL rst_pre: got %h want %h", {m_valid_a, m_data_a}, {1'b1, 32'h61}); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        vectors++; if (rd_en_a !== 1'b0) begin miscompares++;
            $display("FAIL rst_rd_en_held: got %b want 0", rd_en_a); end
        @(negedge clk);
        rst_n = 1'b1;
        vectors++; if ({m_valid_a, halted_a, m_data_a} !== 34'd0) begin miscompares++;
            $display("FAIL rst_clear: got %h want 0", {m_valid_a, halted_a, m_data_a}); end
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (m_valid_a) got.push_back(m_data_a);
            @(negedge clk);
        end
        vectors++; if (got.size() !== 1) begin miscompares++;
            $display("FAIL rst_discard_cnt: got %0d words want 1", got.size()); end
        vectors++; if (got.size() == 0 || got[0] !== 32'h64) begin miscompares++;
            $display("FAIL rst_next_word: got %h want 00000064", (got.size() != 0) ? got[0] : 32'hx); end
    endtask

    task automatic test_err_count();
        int nword = 0, nerr = 0;
        m_ready = 1'b1;
        for (int i = 0; i < 300; i++) push_c(33'h0_0000_0001);
        for (int i = 0; i < 400 && nword < 300; i++) begin
            @(negedge clk);
            if (m_valid_c) begin
                nword++;
                if (m_perr_c) nerr++;
            end
        end
        vectors++; if (nword !== 300 || nerr !== 300) begin miscompares++;
            $display("FAIL cnt_stream: got %0d words %0d errors want 300 300", nword, nerr); end
        vectors++; if ({halted_c, sticky_c} !== 2'b01) begin miscompares++;
            $display("FAIL cnt_flags: got halted,sticky=%b want 01", {halted_c, sticky_c}); end
`ifdef PARITY_ERR_CNT_EN
        vectors++; if (err_cnt_c !== 8'd255) begin miscompares++;
            $display("FAIL cnt_saturate: got %0d want 255", err_cnt_c); end
`endif
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        vectors++; if (sticky_c !== 1'b0) begin miscompares++;
            $display("FAIL cnt_clr_sticky: got %b want 0", sticky_c); end
`ifdef PARITY_ERR_CNT_EN
        vectors++; if (err_cnt_c !== 8'd0) begin miscompares++;
            $display("FAIL cnt_clr: got %0d want 0", err_cnt_c); end
`endif
        push_c(33'h0_0000_0001);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        vectors++; if ({sticky_c, m_valid_c, m_perr_c, halted_c} !== 4'b1110) begin miscompares++;
            $display("FAIL cnt_clr_collide: got sticky,valid,perr,halted=%b want 1110", {sticky_c, m_valid_c, m_perr_c, halted_c}); end
`ifdef PARITY_ERR_CNT_EN
        vectors++; if (err_cnt_c !== 8'd1) begin miscompares++;
            $display("FAIL cnt_clr_collide_cnt: got %0d want 1", err_cnt_c); end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_halt_on_err();
        test_backpressure();
        test_odd_lsb();
        test_reset_inflight();
        test_err_count();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
